// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment table, polarity helper and width helpers for the scan driver
package seg_pkg;

   // Active-high segment patterns, bit order g..a
   localparam logic [6:0] HEX_SEG [0:15] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   localparam logic [7:0] SEG_OFF = 8'h00;

   function automatic logic [7:0] apply_pol(input logic [7:0] pat, input logic active_low);
      return active_low ? ~pat : pat;
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int slot_w(input int scan_ticks);
      return cnt_w(scan_ticks);
   endfunction

   function automatic int digit_w(input int num_digits);
      return cnt_w(num_digits);
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - hex nibble plus decimal point to active-high 8-bit segment pattern
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   input  logic       dp,
   output logic [7:0] pat
);

   assign pat = {dp, HEX_SEG[nib]};

endmodule

// File: rtl/seg_scan_pwm.sv
// rtl/seg_scan_pwm.sv - multiplexed 7-segment scanner with double buffer, blank, blink, PWM and dead time
module seg_scan_pwm
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 6,
   parameter int SCAN_TICKS     = 50000,
   parameter int DEAD_TICKS     = 16,
   parameter int BRIGHT_W       = 4,
   parameter int BLINK_FRAMES   = 64,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int EN_ACTIVE_LOW  = 1
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] din,
   input  logic [NUM_DIGITS-1:0]   dpin,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic [NUM_DIGITS-1:0]   blink_in,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [7:0]              seg_data,
   output logic [NUM_DIGITS-1:0]   seg_en,
   output logic                    frame_start
);

   localparam int SW        = slot_w(SCAN_TICKS);
   localparam int DW        = digit_w(NUM_DIGITS);
   localparam int FW        = cnt_w(BLINK_FRAMES);
   localparam int DUTY_STEP = SCAN_TICKS >> BRIGHT_W;
   localparam logic [7:0]            SEG_IDLE = apply_pol(SEG_OFF, 1'(SEG_ACTIVE_LOW != 0));
   localparam logic [NUM_DIGITS-1:0] EN_IDLE  = {NUM_DIGITS{1'(EN_ACTIVE_LOW != 0)}};

   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] din;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   blank;
      logic [NUM_DIGITS-1:0]   blink;
   } image_t;

   logic [SW-1:0]       slot_cnt;
   logic [DW-1:0]       digit;
   logic [FW-1:0]       frame_cnt;
   logic                blink_phase;
   logic [BRIGHT_W-1:0] bright_lat;
   image_t              shadow;
   image_t              active;

   logic                  slot_end;
   logic                  digit_end;
   logic [31:0]           on_limit;
   logic [4*NUM_DIGITS-1:0] din_sh;
   logic [NUM_DIGITS-1:0] dp_sh;
   logic [NUM_DIGITS-1:0] blank_sh;
   logic [NUM_DIGITS-1:0] blink_sh;
   logic [3:0]            cur_nib;
   logic [7:0]            cur_pat;
   logic [NUM_DIGITS-1:0] en_hot;
   logic                  lit;
   logic [7:0]            seg_next;
   logic [NUM_DIGITS-1:0] en_next;
   logic                  fs_next;

   assign slot_end  = (slot_cnt == SW'(SCAN_TICKS - 1));
   assign digit_end = (digit == DW'(NUM_DIGITS - 1));

   // The active image only changes at slot boundaries, so a digit never shows a half-updated value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt    <= '0;
         digit       <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
         bright_lat  <= '0;
         shadow      <= '0;
         active      <= '0;
      end else begin
         if (load) begin
            shadow <= '{din: din, dp: dpin, blank: blank_in, blink: blink_in};
         end
         if (slot_end) begin
            slot_cnt <= '0;
            active   <= shadow;
            if (digit_end) begin
               digit      <= '0;
               bright_lat <= brightness;
               if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                  frame_cnt   <= '0;
                  blink_phase <= ~blink_phase;
               end else begin
                  frame_cnt <= frame_cnt + 1'b1;
               end
            end else begin
               digit <= digit + 1'b1;
            end
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end
      end
   end

   seg_hex_decode u_dec (
      .nib (cur_nib),
      .dp  (dp_sh[0]),
      .pat (cur_pat)
   );

   always_comb begin
      on_limit = (32'(bright_lat) + 32'd1) * 32'(DUTY_STEP);
      if (&bright_lat) begin
         on_limit = 32'(SCAN_TICKS);
      end
      din_sh   = active.din >> {digit, 2'b00};
      dp_sh    = active.dp >> digit;
      blank_sh = active.blank >> digit;
      blink_sh = active.blink >> digit;
      cur_nib  = din_sh[3:0];
      en_hot        = '0;
      en_hot[digit] = 1'b1;
      lit = (32'(slot_cnt) >= 32'(DEAD_TICKS)) && (32'(slot_cnt) < on_limit)
            && !blank_sh[0] && !(blink_sh[0] && blink_phase);
      seg_next = lit ? apply_pol(cur_pat, 1'(SEG_ACTIVE_LOW != 0)) : SEG_IDLE;
      en_next  = lit ? (en_hot ^ EN_IDLE) : EN_IDLE;
      fs_next  = (slot_cnt == '0) && (digit == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_data    <= SEG_IDLE;
         seg_en      <= EN_IDLE;
         frame_start <= 1'b0;
      end else begin
         seg_data    <= seg_next;
         seg_en      <= en_next;
         frame_start <= fs_next;
      end
   end

endmodule

// File: tb/tb_seg_scan_pwm.sv
// tb/tb_seg_scan_pwm.sv - directed self-checking bench for seg_scan_pwm (4 digits, 16-tick slots)
module tb_seg_scan_pwm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [15:0] din;
   logic [3:0]  dpin;
   logic [3:0]  blank_in;
   logic [3:0]  blink_in;
   logic [1:0]  brightness;
   logic [7:0]  seg_data;
   logic [3:0]  seg_en;
   logic        frame_start;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   seg_scan_pwm #(
      .NUM_DIGITS     (4),
      .SCAN_TICKS     (16),
      .DEAD_TICKS     (1),
      .BRIGHT_W       (2),
      .BLINK_FRAMES   (2),
      .SEG_ACTIVE_LOW (1),
      .EN_ACTIVE_LOW  (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .din         (din),
      .dpin        (dpin),
      .blank_in    (blank_in),
      .blink_in    (blink_in),
      .brightness  (brightness),
      .seg_data    (seg_data),
      .seg_en      (seg_en),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   // One 16-cycle slot: lit for 1 <= p < on_lim; optionally raises load after position load_at
   task automatic chk_slot(input int dig, input logic [7:0] lit_seg, input int on_lim, input int load_at);
      logic       lit;
      logic [3:0] e_en;
      logic [7:0] e_seg;
      for (int p = 0; p < 16; p++) begin
         @(negedge clk);
         cyc++;
         load  = 1'b0;
         lit   = (p >= 1) && (p < on_lim);
         e_en  = lit ? ~(4'b0001 << dig) : 4'b1111;
         e_seg = lit ? lit_seg : 8'hFF;
         chk("seg_en", {4'h0, seg_en}, {4'h0, e_en});
         chk("seg_data", seg_data, e_seg);
         chk("frame_start", {7'h0, frame_start}, {7'h0, (dig == 0 && p == 0)});
         if (p == load_at) load = 1'b1;
      end
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; din = '0; dpin = '0;
      blank_in = '0; blink_in = '0; brightness = '0;
      repeat (2) @(negedge clk);
      chk("rst_seg_en", {4'h0, seg_en}, 8'h0F);
      chk("rst_seg_data", seg_data, 8'hFF);
      chk("rst_frame_start", {7'h0, frame_start}, 8'h00);

      // Frame 0 still runs at the reset brightness (0); new image shows from digit 1
      rst_n = 1'b1; din = 16'h3210; brightness = 2'd3; load = 1'b1;
      chk_slot(0, 8'hC0, 4, -1);
      chk_slot(1, 8'hF9, 4, -1);
      chk_slot(2, 8'hA4, 4, -1);
      chk_slot(3, 8'hB0, 4, -1);
      // Frame 1: full brightness; a mid-frame change must not take effect yet
      chk_slot(0, 8'hC0, 16, -1);
      chk_slot(1, 8'hF9, 16, -1);
      chk_slot(2, 8'hA4, 16, -1);
      brightness = 2'd0;
      chk_slot(3, 8'hB0, 16, -1);
      // Frame 2: dimmest
      chk_slot(0, 8'hC0, 4, -1);
      chk_slot(1, 8'hF9, 4, -1);
      brightness = 2'd2;
      chk_slot(2, 8'hA4, 4, -1);
      chk_slot(3, 8'hB0, 4, -1);
      // Frame 3: brightness 2 -> on_limit 12
      chk_slot(0, 8'hC0, 12, -1);
      chk_slot(1, 8'hF9, 12, -1);
      chk_slot(2, 8'hA4, 12, -1);
      chk_slot(3, 8'hB0, 12, -1);
      // Frame 4: decimal point on digit 2, digit 3 blanked
      dpin = 4'b0100; blank_in = 4'b1000; load = 1'b1;
      chk_slot(0, 8'hC0, 12, -1);
      chk_slot(1, 8'hF9, 12, -1);
      chk_slot(2, 8'h24, 12, -1);
      chk_slot(3, 8'hFF, 0, -1);
      // Frame 5 (blink phase 0): digit 0 blinks
      dpin = 4'b0000; blank_in = 4'b0000; blink_in = 4'b0001; load = 1'b1;
      chk_slot(0, 8'hC0, 12, -1);
      chk_slot(1, 8'hF9, 12, -1);
      chk_slot(2, 8'hA4, 12, -1);
      chk_slot(3, 8'hB0, 12, -1);
      // Frames 6-7 (blink phase 1): digit 0 dark, others unaffected
      for (int f = 0; f < 2; f++) begin
         chk_slot(0, 8'hFF, 0, -1);
         chk_slot(1, 8'hF9, 12, -1);
         chk_slot(2, 8'hA4, 12, -1);
         chk_slot(3, 8'hB0, 12, -1);
      end
      // Frame 8 (phase 0 again)
      chk_slot(0, 8'hC0, 12, -1);
      chk_slot(1, 8'hF9, 12, -1);
      chk_slot(2, 8'hA4, 12, -1);
      chk_slot(3, 8'hB0, 12, -1);
      // Frame 9: load lands in the boundary cycle into digit 1
      din = 16'hFFFF; blink_in = 4'b0000;
      chk_slot(0, 8'hC0, 12, 14);
      chk_slot(1, 8'hF9, 12, -1);
      chk_slot(2, 8'h8E, 12, -1);
      chk_slot(3, 8'h8E, 12, -1);
      // Mid-slot asynchronous reset
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_seg_en", {4'h0, seg_en}, 8'h0F);
      chk("midrst_seg_data", seg_data, 8'hFF);
      chk("midrst_frame_start", {7'h0, frame_start}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1; din = 16'h0000; dpin = 4'b0001; brightness = 2'd3; load = 1'b1;
      chk_slot(0, 8'hC0, 4, -1);
      chk_slot(1, 8'hC0, 4, -1);
      chk_slot(2, 8'hC0, 4, -1);
      chk_slot(3, 8'hC0, 4, -1);
      chk_slot(0, 8'h40, 16, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
